// File: rtl/spi_device_shifter_if.sv
// Handshake/data bundle between the SPI edge front-end, the device shifter and the command decoder.
// SPI_DEVICE_SHIFTER_UNDERRUN_EN adds tx_underrun and rx_overrun_count.
interface spi_device_shifter_if #(
  parameter int WIDTH = 8
);
  logic                     sck_rising;
  logic                     sck_falling;
  logic                     cs_n;
  logic                     mosi;
  logic                     miso;
  logic [WIDTH-1:0]         rx_data;
  logic                     rx_strobe;
  logic                     cs_start;
  logic                     cs_end;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [$clog2(WIDTH)-1:0] bit_count;
`ifdef SPI_DEVICE_SHIFTER_UNDERRUN_EN
  logic                     tx_underrun;
  logic [7:0]               rx_overrun_count;

  modport master (
    output sck_rising, sck_falling, cs_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_strobe, cs_start, cs_end, tx_ready, bit_count,
           tx_underrun, rx_overrun_count
  );
  modport slave (
    input  sck_rising, sck_falling, cs_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_strobe, cs_start, cs_end, tx_ready, bit_count,
           tx_underrun, rx_overrun_count
  );
`else
  modport master (
    output sck_rising, sck_falling, cs_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_strobe, cs_start, cs_end, tx_ready, bit_count
  );
  modport slave (
    input  sck_rising, sck_falling, cs_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_strobe, cs_start, cs_end, tx_ready, bit_count
  );
`endif
endinterface

// File: rtl/spi_device_shifter.sv
// SPI mode-0 device shifter: bytes in from MOSI, buffered response word out on MISO, CS framing pulses.
// Optional macro SPI_DEVICE_SHIFTER_UNDERRUN_EN adds tx_underrun and rx_overrun_count.
module spi_device_shifter #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  spi_device_shifter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_rx, shift_tx, hold, rx_data_q;
  logic             hold_full, rx_strobe_q, cs_start_q, cs_end_q;
  logic [CW-1:0]    bit_count_q;
  logic             enter, leave, rise, fall, word_done, tx_load, capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.cs_n) state_nxt = ACTIVE;
      ACTIVE:  if (bus.cs_n)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cs_n deassertion masks any sck strobe in the same cycle; rising wins over falling.
  always_comb begin
    enter     = (state == IDLE) && !bus.cs_n;
    leave     = (state == ACTIVE) && bus.cs_n;
    rise      = (state == ACTIVE) && !bus.cs_n && bus.sck_rising;
    fall      = (state == ACTIVE) && !bus.cs_n && bus.sck_falling && !bus.sck_rising;
    word_done = rise && (bit_count_q == CW'(WIDTH - 1));
    tx_load   = enter || word_done;
    capture   = bus.tx_valid && !hold_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_rx    <= '0;
      shift_tx    <= '1;
      hold        <= '0;
      hold_full   <= 1'b0;
      rx_data_q   <= '0;
      rx_strobe_q <= 1'b0;
      cs_start_q  <= 1'b0;
      cs_end_q    <= 1'b0;
      bit_count_q <= '0;
    end else begin
      rx_strobe_q <= word_done;
      cs_start_q  <= enter;
      cs_end_q    <= leave;

      if (enter || leave) begin
        bit_count_q <= '0;
        shift_rx    <= '0;
      end else if (rise) begin
        shift_rx    <= {shift_rx[WIDTH-2:0], bus.mosi};
        bit_count_q <= word_done ? '0 : bit_count_q + CW'(1);
      end

      if (word_done) rx_data_q <= {shift_rx[WIDTH-2:0], bus.mosi};

      // Boundary falling edge (bit_count==0) keeps the freshly loaded MSB on the wire.
      if (tx_load)                       shift_tx <= hold_full ? hold : '1;
      else if (fall && bit_count_q != '0) shift_tx <= {shift_tx[WIDTH-2:0], 1'b1};

      // A capture coinciding with a load: the load already sampled the old contents.
      if (capture) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign bus.miso      = (state == ACTIVE) ? shift_tx[WIDTH-1] : 1'b1;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_strobe = rx_strobe_q;
  assign bus.cs_start  = cs_start_q;
  assign bus.cs_end    = cs_end_q;
  assign bus.tx_ready  = !hold_full;
  assign bus.bit_count = bit_count_q;

`ifdef SPI_DEVICE_SHIFTER_UNDERRUN_EN
  logic       underrun_q;
  logic [7:0] overrun_q;

  // The decoder's only consumption window is the strobe cycle; a word completing
  // while the previous strobe is still high gave it zero cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
      overrun_q  <= 8'd0;
    end else begin
      underrun_q <= tx_load && !hold_full;
      if (word_done && rx_strobe_q && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
    end
  end

  assign bus.tx_underrun      = underrun_q;
  assign bus.rx_overrun_count = overrun_q;
`endif
endmodule

// File: tb/tb_spi_device_shifter.sv
// Directed self-checking bench for spi_device_shifter (WIDTH=8), SPI mode 0, MSB first.
module tb_spi_device_shifter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0, start_cnt = 0, end_cnt = 0, underrun_cnt = 0;

  spi_device_shifter_if #(.WIDTH(8)) bus ();
  spi_device_shifter #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.rx_strobe) strobe_cnt++;
    if (bus.cs_start)  start_cnt++;
    if (bus.cs_end)    end_cnt++;
`ifdef SPI_DEVICE_SHIFTER_UNDERRUN_EN
    if (bus.tx_underrun) underrun_cnt++;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hold(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
  endtask

  // Clocks n bits MSB-first; returns MISO as seen at each rising edge and rx_strobe right after the last rise.
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] m, output logic last_strobe);
    m = 8'h00;
    last_strobe = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      m = {m[6:0], bus.miso};
      bus.sck_rising = 1'b1;
      tick();
      bus.sck_rising = 1'b0;
      last_strobe = bus.rx_strobe;
      tick();
      bus.sck_falling = 1'b1;
      tick();
      bus.sck_falling = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sck_rising = 0; bus.sck_falling = 0; bus.cs_n = 1; bus.mosi = 0;
    bus.tx_data = 0; bus.tx_valid = 0;
    #12;
    checks++; if (bus.miso !== 1'b1)        begin errors++; $display("FAIL reset_miso: got %b want 1", bus.miso); end
    checks++; if (bus.rx_data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    checks++; if (bus.rx_strobe !== 1'b0)   begin errors++; $display("FAIL reset_rx_strobe: got %b want 0", bus.rx_strobe); end
    checks++; if (bus.cs_start !== 1'b0 || bus.cs_end !== 1'b0) begin errors++; $display("FAIL reset_cs_pulses: got %b%b want 00", bus.cs_start, bus.cs_end); end
    checks++; if (bus.tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.bit_count !== 3'd0)   begin errors++; $display("FAIL reset_bit_count: got %0d want 0", bus.bit_count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] m;
    logic ls;
    int s0, st0;
    s0 = strobe_cnt; st0 = start_cnt;
    load_hold(8'hA5);
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL word_tx_ready_full: got %b want 0", bus.tx_ready); end
    bus.cs_n = 1'b0;
    tick();
    checks++; if (bus.cs_start !== 1'b1) begin errors++; $display("FAIL word_cs_start: got %b want 1", bus.cs_start); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL word_tx_ready_after_load: got %b want 1", bus.tx_ready); end
    send_bits(8'h3C, 8, m, ls);
    checks++; if (m !== 8'hA5)           begin errors++; $display("FAIL word_miso: got %h want a5", m); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL word_rx_data: got %h want 3c", bus.rx_data); end
    checks++; if (ls !== 1'b1)           begin errors++; $display("FAIL word_strobe_timing: got %b want 1", ls); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL word_strobe_count: got %0d want 1", strobe_cnt - s0); end
    checks++; if (start_cnt - st0 !== 1) begin errors++; $display("FAIL word_start_count: got %0d want 1", start_cnt - st0); end
    checks++; if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL word_bit_count: got %0d want 0", bus.bit_count); end
    bus.cs_n = 1'b1;
    tick();
    checks++; if (bus.cs_end !== 1'b1)   begin errors++; $display("FAIL word_cs_end: got %b want 1", bus.cs_end); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] m;
    logic ls;
    int s0;
    s0 = strobe_cnt;
    load_hold(8'hC3);
    bus.cs_n = 1'b0;
    tick();
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_first: got %b want 1", bus.tx_ready); end
    load_hold(8'h5A);
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", bus.tx_ready); end
    send_bits(8'h81, 8, m, ls);
    checks++; if (m !== 8'hC3)           begin errors++; $display("FAIL b2b_miso_1: got %h want c3", m); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_between: got %b want 1", bus.tx_ready); end
    checks++; if (bus.miso !== 1'b0)     begin errors++; $display("FAIL b2b_boundary_msb: got %b want 0", bus.miso); end
    send_bits(8'h7E, 8, m, ls);
    checks++; if (m !== 8'h5A)           begin errors++; $display("FAIL b2b_miso_2: got %h want 5a", m); end
    checks++; if (bus.rx_data !== 8'h7E) begin errors++; $display("FAIL b2b_rx_data: got %h want 7e", bus.rx_data); end
    checks++; if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_strobe_count: got %0d want 2", strobe_cnt - s0); end
    bus.cs_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_abort();
    logic [7:0] m;
    logic ls;
    int s0;
    s0 = strobe_cnt;
    bus.cs_n = 1'b0;
    tick();
    send_bits(8'hAB, 5, m, ls);
    checks++; if (bus.bit_count !== 3'd5) begin errors++; $display("FAIL abort_partial_count: got %0d want 5", bus.bit_count); end
    bus.cs_n = 1'b1;
    tick();
    checks++; if (bus.cs_end !== 1'b1)    begin errors++; $display("FAIL abort_cs_end: got %b want 1", bus.cs_end); end
    checks++; if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL abort_bit_count: got %0d want 0", bus.bit_count); end
    tick();
    checks++; if (strobe_cnt - s0 !== 0)  begin errors++; $display("FAIL abort_no_strobe: got %0d want 0", strobe_cnt - s0); end
    checks++; if (bus.rx_data !== 8'h7E)  begin errors++; $display("FAIL abort_rx_hold: got %h want 7e", bus.rx_data); end
    load_hold(8'h96);
    bus.cs_n = 1'b0;
    tick();
    send_bits(8'hF0, 8, m, ls);
    checks++; if (m !== 8'h96)            begin errors++; $display("FAIL abort_next_miso: got %h want 96", m); end
    checks++; if (bus.rx_data !== 8'hF0)  begin errors++; $display("FAIL abort_next_rx: got %h want f0", bus.rx_data); end
    bus.cs_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_empty_holding();
    logic [7:0] m;
    logic ls;
    int u0;
    u0 = underrun_cnt;
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b want 1", bus.tx_ready); end
    bus.cs_n = 1'b0;
    tick();
    load_hold(8'h00);  // fills the buffer so the word-boundary reload is not an underrun
    send_bits(8'h55, 8, m, ls);
    checks++; if (m !== 8'hFF)           begin errors++; $display("FAIL empty_miso: got %h want ff", m); end
    checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL empty_rx_data: got %h want 55", bus.rx_data); end
`ifdef SPI_DEVICE_SHIFTER_UNDERRUN_EN
    checks++; if (underrun_cnt - u0 !== 1) begin errors++; $display("FAIL empty_underrun: got %0d want 1", underrun_cnt - u0); end
`else
    u0 = u0 + 0;
`endif
    bus.cs_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    logic ls;
    int e0;
    load_hold(8'h00);
    bus.cs_n = 1'b0;
    tick();
    load_hold(8'h42);
    send_bits(8'hFF, 3, m, ls);
    checks++; if (bus.miso !== 1'b0 || bus.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_pre: got miso=%b ready=%b want 0 0", bus.miso, bus.tx_ready); end
    e0 = end_cnt;
    reset = 1'b1;
    #1;
    checks++; if (bus.miso !== 1'b1)      begin errors++; $display("FAIL rst_async_miso: got %b want 1", bus.miso); end
    checks++; if (bus.tx_ready !== 1'b1)  begin errors++; $display("FAIL rst_async_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d want 0", bus.bit_count); end
    checks++; if (bus.rx_data !== 8'h00)  begin errors++; $display("FAIL rst_async_rx: got %h want 00", bus.rx_data); end
    bus.cs_n = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    checks++; if (end_cnt - e0 !== 0)     begin errors++; $display("FAIL rst_no_cs_end: got %0d want 0", end_cnt - e0); end
  endtask

  task automatic test_rise_with_cs_end();
    logic [7:0] m;
    logic ls;
    int s0;
    bus.cs_n = 1'b0;
    tick();
    send_bits(8'hFF, 7, m, ls);
    s0 = strobe_cnt;
    bus.mosi = 1'b1;
    bus.cs_n = 1'b1;
    bus.sck_rising = 1'b1;
    tick();
    bus.sck_rising = 1'b0;
    checks++; if (bus.bit_count !== 3'd0) begin errors++; $display("FAIL rise_cs_bit_count: got %0d want 0", bus.bit_count); end
    checks++; if (bus.cs_end !== 1'b1)    begin errors++; $display("FAIL rise_cs_end: got %b want 1", bus.cs_end); end
    tick(); tick();
    checks++; if (strobe_cnt - s0 !== 0)  begin errors++; $display("FAIL rise_cs_no_strobe: got %0d want 0", strobe_cnt - s0); end
    checks++; if (bus.rx_data !== 8'h00)  begin errors++; $display("FAIL rise_cs_rx_hold: got %h want 00", bus.rx_data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_empty_holding();
    test_reset_mid();
    test_rise_with_cs_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_device_shifter.md
Name: spi_device_shifter

Overview:
- SPI mode-0 device-side shifter for the flash emulator datapath.
- Sits directly downstream of the `edge` detector and input synchronisers. It consumes SCK rising/falling strobes that are already in the clk domain, plus synchronised CS_n and MOSI.
- Assembles MOSI bits into bytes and serialises a buffered response byte onto MISO.
- Feeds the command decoder with byte strobes and chip-select framing pulses.

Parameters:
- WIDTH, 8, word size in bits; must be at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sck_rising  input  1  one-cycle strobe for an SCK rising edge (from `edge`)
- sck_falling  input  1  one-cycle strobe for an SCK falling edge (from `edge`)
- cs_n  input  1  synchronised chip select, active low
- mosi  input  1  synchronised MOSI, delay-matched to the sck strobes
- miso  output  1  serial data out
- rx_data  output  WIDTH  last complete received word
- rx_strobe  output  1  one-cycle pulse: rx_data has been updated
- cs_start  output  1  one-cycle pulse on CS_n assertion
- cs_end  output  1  one-cycle pulse on CS_n deassertion
- tx_data  input  WIDTH  next response word
- tx_valid  input  1  tx_data offered
- tx_ready  output  1  holding register empty
- bit_count  output  CLOG2(WIDTH)  bits received in the current word

Behaviour:
- Reset values: miso=1, rx_data=0, rx_strobe=0, cs_start=0, cs_end=0, tx_ready=1, bit_count=0; holding register empty; state IDLE.
- Reset mid-transfer aborts immediately. The partial word is discarded; no cs_end pulse.
- State IDLE (cs_n=1):
  - sck strobes are ignored.
  - miso=1.
  - The holding register still accepts tx_data.
- IDLE -> ACTIVE when a clk edge sees cs_n=0:
  - cs_start pulses for 1 cycle.
  - bit_count=0.
  - The TX shift register is loaded from the holding register if it is full (holding register is then emptied), else from all-ones.
  - miso = shift_tx[WIDTH-1] from the next cycle.
- ACTIVE -> IDLE when cs_n=1:
  - cs_end pulses for 1 cycle.
  - bit_count=0; partial RX bits are discarded; no rx_strobe.
  - cs_n=1 takes priority over a simultaneous sck_rising or sck_falling.
- In ACTIVE, sck_rising:
  - Shift mosi into the LSB of shift_rx.
  - bit_count increments.
  - On the WIDTH-th bit: rx_data <= {shift_rx[WIDTH-2:0], mosi}, rx_strobe pulses the next cycle, bit_count wraps to 0, and the TX shift register reloads using the same rule as at IDLE -> ACTIVE.
- In ACTIVE, sck_falling:
  - If bit_count!=0, shift_tx shifts left one bit (fill with 1) and miso updates.
  - If bit_count==0, no shift. The word-boundary falling edge keeps the freshly loaded MSB.
- sck_rising and sck_falling asserted together is illegal upstream; rising is processed and falling is ignored.
- Holding-register handshake:
  - tx_valid && tx_ready captures tx_data; tx_ready drops the next cycle.
  - tx_ready rises the cycle after the holding register is transferred into the shift register.
  - A load and a new capture in the same cycle are allowed. The shift register takes the old value, the holding register takes the new one, and tx_ready stays 0.
- rx_data holds until the next complete word.
- Output latency: rx_strobe, cs_start and cs_end are all registered, 1 cycle after the triggering input cycle.

Optional Feature:
- Macro: SPI_DEVICE_SHIFTER_UNDERRUN_EN.
- Defined:
  - Adds output port tx_underrun (1 bit).
  - tx_underrun pulses for 1 cycle whenever a TX load occurs in ACTIVE or at cs_start while the holding register is empty; all-ones is shifted out.
  - Adds output rx_overrun_count (8 bits, saturating at 255, cleared by reset), which increments when rx_strobe fires with zero intervening cycles of rx consumption.
- Undefined:
  - Neither port exists.
  - The empty-buffer load silently shifts all-ones.

Test Plan:
- cs_n falls, holding loaded with 0xA5, then 8 rising/falling pairs with mosi=0x3C MSB-first:
  - cs_start pulses once.
  - miso sequence is 1,0,1,0,0,1,0,1.
  - rx_data=0x3C with a single rx_strobe 1 cycle after the 8th sck_rising.
  - bit_count returns to 0.
- Back-to-back words, holding reloaded with 0x5A after the first load:
  - Second word's miso is 0x5A.
  - The word-boundary falling edge does not shift.
  - tx_ready pulses high between words.
- cs_n rises after 5 bits:
  - cs_end pulses, no rx_strobe, rx_data unchanged, bit_count=0.
  - The next transaction starts clean.
- Empty holding register at cs_start:
  - miso stays 1 for all 8 bits.
  - With SPI_DEVICE_SHIFTER_UNDERRUN_EN defined, tx_underrun pulses exactly once.
- Assert reset at bit 3:
  - All outputs return to reset values asynchronously (miso=1, tx_ready=1).
  - No cs_end pulse.
- Assert sck_rising in the same cycle cs_n rises:
  - The bit is not sampled; bit_count=0.
  - cs_end pulses.
